// File: rtl/pwr_domain_seq.sv
// rtl/pwr_domain_seq.sv - per-domain power-gating sequencer (isolation, domain reset, switch control)
// Optional ack-timeout/ERR handling is enabled by defining PWR_DOMAIN_SEQ_TIMEOUT_EN.
module pwr_domain_seq #(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 64,
  parameter bit RESET_ON       = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic off_req_i,
  input  logic on_req_i,
  output logic switch_no,
  input  logic switch_ack_ni,
  output logic iso_no,
  output logic rst_domain_no,
  output logic busy_o,
  output logic powered_o,
  output logic err_o,
  input  logic err_clr_i
);

  typedef enum logic [3:0] {
    ST_ON,
    ST_ISO,
    ST_RST,
    ST_SW_OFF,
    ST_OFF,
    ST_SW_ON,
    ST_RST_REL,
    ST_ISO_REL
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
    ,
    ST_ERR
`endif
  } state_e;

  localparam state_e     RESET_STATE = RESET_ON ? ST_ON : ST_OFF;
  // Settle count is loaded with N-1 so a state lasts exactly N cycles.
  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       switch_no_q, switch_no_d;
  logic       iso_no_q, iso_no_d;
  logic       rst_domain_no_q, rst_domain_no_d;
  logic       busy_q, busy_d;
  logic       powered_q, powered_d;
  logic       err_q, err_d;

`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_q, wait_d;
  logic        ret_on_q, ret_on_d;
`else
  logic        unused_err_clr;
  logic [15:0] unused_timeout;
  assign unused_err_clr = err_clr_i;
  assign unused_timeout = TIMEOUT_CYCLES[15:0];
`endif

  always_comb begin
    state_d         = state_q;
    cnt_d           = cnt_q;
    switch_no_d     = switch_no_q;
    iso_no_d        = iso_no_q;
    rst_domain_no_d = rst_domain_no_q;
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
    wait_d          = wait_q;
    ret_on_d        = ret_on_q;
`endif
    unique case (state_q)
      ST_ON: begin
        if (off_req_i) begin
          state_d  = ST_ISO;
          iso_no_d = 1'b0;
          cnt_d    = SETTLE_LOAD;
        end
      end
      ST_ISO: begin
        if (cnt_q == 8'd0) begin
          state_d         = ST_RST;
          rst_domain_no_d = 1'b0;
          cnt_d           = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_RST: begin
        if (cnt_q == 8'd0) begin
          state_d     = ST_SW_OFF;
          switch_no_d = 1'b1;
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
          wait_d      = 16'd0;
`endif
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_SW_OFF: begin
        if (switch_ack_ni) begin
          state_d = ST_OFF;
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
        end else if (wait_q == TIMEOUT_LAST) begin
          state_d  = ST_ERR;
          ret_on_d = 1'b0;
        end else begin
          wait_d = wait_q + 16'd1;
`endif
        end
      end
      ST_OFF: begin
        if (on_req_i) begin
          state_d     = ST_SW_ON;
          switch_no_d = 1'b0;
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
          wait_d      = 16'd0;
`endif
        end
      end
      ST_SW_ON: begin
        if (!switch_ack_ni) begin
          state_d         = ST_RST_REL;
          rst_domain_no_d = 1'b1;
          cnt_d           = SETTLE_LOAD;
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
        end else if (wait_q == TIMEOUT_LAST) begin
          state_d  = ST_ERR;
          ret_on_d = 1'b1;
        end else begin
          wait_d = wait_q + 16'd1;
`endif
        end
      end
      ST_RST_REL: begin
        if (cnt_q == 8'd0) begin
          state_d  = ST_ISO_REL;
          iso_no_d = 1'b1;
          cnt_d    = SETTLE_LOAD;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      ST_ISO_REL: begin
        if (cnt_q == 8'd0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
      // Ack is deliberately not looked at here; only a clear retries the wait.
      ST_ERR: begin
        if (err_clr_i) begin
          state_d = ret_on_q ? ST_SW_ON : ST_SW_OFF;
          wait_d  = 16'd0;
        end
      end
`endif
      default: state_d = RESET_STATE;
    endcase

    busy_d    = (state_d != ST_ON) && (state_d != ST_OFF);
    powered_d = (state_d == ST_ON);
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
    err_d     = (state_d == ST_ERR);
`else
    err_d     = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= RESET_STATE;
      cnt_q           <= 8'd0;
      switch_no_q     <= !RESET_ON;
      iso_no_q        <= RESET_ON;
      rst_domain_no_q <= RESET_ON;
      busy_q          <= 1'b0;
      powered_q       <= RESET_ON;
      err_q           <= 1'b0;
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
      wait_q          <= 16'd0;
      ret_on_q        <= 1'b0;
`endif
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      switch_no_q     <= switch_no_d;
      iso_no_q        <= iso_no_d;
      rst_domain_no_q <= rst_domain_no_d;
      busy_q          <= busy_d;
      powered_q       <= powered_d;
      err_q           <= err_d;
`ifdef PWR_DOMAIN_SEQ_TIMEOUT_EN
      wait_q          <= wait_d;
      ret_on_q        <= ret_on_d;
`endif
    end
  end

  assign switch_no     = switch_no_q;
  assign iso_no        = iso_no_q;
  assign rst_domain_no = rst_domain_no_q;
  assign busy_o        = busy_q;
  assign powered_o     = powered_q;
  assign err_o         = err_q;

endmodule
